// File: rtl/csa_accum.sv
// Packet accumulator that keeps the running sum in carry-save form (S, C).
// The single carry-propagate add happens once per packet, in RES.
module csa_accum #(
    parameter int width     = 16,
    parameter int acc_width = 24,
    parameter int signd     = 0
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 clr,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [width-1:0]     in_dat,
    input  logic                 in_last,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [acc_width-1:0] out_dat,
    output logic [15:0]          out_cnt
);

    // state  | meaning
    // ST_ACC | accepting operands into S/C
    // ST_RES | resolving S+C into the output register
    // ST_OUT | result presented, waiting for out_rdy
    typedef enum logic [1:0] {ST_ACC, ST_RES, ST_OUT} state_t;

    state_t               state_q, state_d;
    logic [acc_width-1:0] s_q, s_d;
    logic [acc_width-1:0] c_q, c_d;
    logic [acc_width-1:0] out_dat_q, out_dat_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          out_cnt_q, out_cnt_d;
    logic                 in_rdy_q, in_rdy_d;
    logic                 out_vld_q, out_vld_d;
    logic [acc_width-1:0] x_ext;
    logic [acc_width-1:0] maj;
    logic                 xfer;

    generate
        if (acc_width > width) begin : g_ext
            logic fill;
            assign fill  = (signd != 0) ? in_dat[width-1] : 1'b0;
            assign x_ext = {{(acc_width-width){fill}}, in_dat};
        end else begin : g_noext
            assign x_ext = in_dat;
        end
    endgenerate

    assign maj  = (s_q & c_q) | (c_q & x_ext) | (x_ext & s_q);
    assign xfer = in_vld & in_rdy_q;

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        out_dat_d = out_dat_q;
        out_cnt_d = out_cnt_q;
        in_rdy_d  = in_rdy_q;
        out_vld_d = out_vld_q;

        if (clr) begin
            s_d     = '0;
            c_d     = '0;
            cnt_d   = '0;
            state_d = ST_ACC;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (xfer) begin
                        s_d   = s_q ^ c_q ^ x_ext;
                        c_d   = maj << 1;
                        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                        if (in_last) begin
                            state_d = ST_RES;
                        end
                    end
                end
                ST_RES: begin
                    out_dat_d = s_q + c_q;
                    out_cnt_d = cnt_q;
                    state_d   = ST_OUT;
                end
                ST_OUT: begin
                    if (out_rdy) begin
                        s_d     = '0;
                        c_d     = '0;
                        cnt_d   = '0;
                        state_d = ST_ACC;
                    end
                end
                default: begin
                    state_d = ST_ACC;
                end
            endcase
        end

        // Handshake outputs are registered and follow the next state directly.
        in_rdy_d  = (state_d == ST_ACC);
        out_vld_d = (state_d == ST_OUT);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= ST_ACC;
            s_q       <= '0;
            c_q       <= '0;
            cnt_q     <= '0;
            out_dat_q <= '0;
            out_cnt_q <= '0;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            out_dat_q <= out_dat_d;
            out_cnt_q <= out_cnt_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign in_rdy  = in_rdy_q;
    assign out_vld = out_vld_q;
    assign out_dat = out_dat_q;
    assign out_cnt = out_cnt_q;

endmodule
